// File: rtl/ibex_sec_lsmask_gen.sv
// Secure load/store mask generator: xorshift128 PRNG seeded through CSR writes,
// offering one 32-bit mask per valid/ready handshake after a warmup period.
module ibex_sec_lsmask_gen #(
  parameter int unsigned WarmupSteps = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        seed_we_i,
  input  logic [1:0]  seed_idx_i,
  input  logic [31:0] seed_wdata_i,
  output logic        mask_valid_o,
  output logic [31:0] mask_o,
  input  logic        mask_ready_i,
  output logic        seeded_o
);

  typedef enum logic [1:0] {
    UNSEEDED,
    WARMUP,
    READY
  } fsm_e;

  localparam logic [3:0] WarmInit = 4'(WarmupSteps);

  fsm_e        fsm_q, fsm_d;
  logic [31:0] x_q, y_q, z_q, w_q;
  logic [31:0] x_d, y_d, z_d, w_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mask_valid_q, mask_valid_d;

  logic [31:0] t_step, w_step;
  logic [31:0] x_seed, y_seed, z_seed, w_seed;
  logic        seed_nonzero;

  assign t_step = x_q ^ (x_q << 11);
  assign w_step = w_q ^ (w_q >> 19) ^ t_step ^ (t_step >> 8);

  // A seed write patches one word of the current, un-advanced state.
  assign x_seed = (seed_idx_i == 2'd0) ? seed_wdata_i : x_q;
  assign y_seed = (seed_idx_i == 2'd1) ? seed_wdata_i : y_q;
  assign z_seed = (seed_idx_i == 2'd2) ? seed_wdata_i : z_q;
  assign w_seed = (seed_idx_i == 2'd3) ? seed_wdata_i : w_q;
  assign seed_nonzero = |{x_seed, y_seed, z_seed, w_seed};

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    w_d   = w_q;
    if (seed_we_i) begin
      x_d = x_seed;
      y_d = y_seed;
      z_d = z_seed;
      w_d = w_seed;
      cnt_d = WarmInit;
      if (!seed_nonzero) begin
        fsm_d = UNSEEDED;
      end else if (WarmupSteps == 0) begin
        fsm_d = READY;
      end else begin
        fsm_d = WARMUP;
      end
    end else begin
      case (fsm_q)
        WARMUP: begin
          if (cnt_q == 4'd0) begin
            fsm_d = READY;
          end else begin
            x_d   = y_q;
            y_d   = z_q;
            z_d   = w_q;
            w_d   = w_step;
            cnt_d = cnt_q - 4'd1;
          end
        end
        READY: begin
          if (mask_ready_i) begin
            x_d = y_q;
            y_d = z_q;
            z_d = w_q;
            w_d = w_step;
          end
        end
        default: ;
      endcase
    end
    mask_valid_d = (fsm_d == READY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q        <= UNSEEDED;
      cnt_q        <= 4'd0;
      x_q          <= 32'd0;
      y_q          <= 32'd0;
      z_q          <= 32'd0;
      w_q          <= 32'd0;
      mask_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      w_q          <= w_d;
      mask_valid_q <= mask_valid_d;
    end
  end

  assign mask_valid_o = mask_valid_q;
  assign mask_o       = mask_valid_q ? w_q : 32'd0;
  assign seeded_o     = |{x_q, y_q, z_q, w_q};

endmodule

// File: tb/tb_ibex_sec_lsmask_gen.sv
// Bench for ibex_sec_lsmask_gen: two instances (WarmupSteps 0 and 4) checked
// every cycle against a word-array reference model, plus directed checks.
module tb_ibex_sec_lsmask_gen;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        seed_we = 1'b0;
  logic [1:0]  seed_idx = 2'd0;
  logic [31:0] seed_wdata = 32'd0;
  logic        mask_ready = 1'b0;

  logic        valid0, valid4, seeded0, seeded4;
  logic [31:0] mask0, mask4;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ibex_sec_lsmask_gen #(.WarmupSteps(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .seed_we_i(seed_we), .seed_idx_i(seed_idx),
    .seed_wdata_i(seed_wdata), .mask_valid_o(valid0), .mask_o(mask0),
    .mask_ready_i(mask_ready), .seeded_o(seeded0)
  );

  ibex_sec_lsmask_gen #(.WarmupSteps(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .seed_we_i(seed_we), .seed_idx_i(seed_idx),
    .seed_wdata_i(seed_wdata), .mask_valid_o(valid4), .mask_o(mask4),
    .mask_ready_i(mask_ready), .seeded_o(seeded4)
  );

  // Reference model: per instance, four state words, a phase (0 unseeded,
  // 1 warming, 2 ready) and the number of invalid cycles still to run.
  logic [31:0] m_st [2][4];
  int          m_ph [2];
  int          m_left [2];
  int          m_warm [2] = '{0, 4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_advance(input int k);
    logic [31:0] t, nw;
    t  = m_st[k][0] ^ (m_st[k][0] << 11);
    nw = m_st[k][3] ^ (m_st[k][3] >> 19) ^ t ^ (t >> 8);
    m_st[k][0] = m_st[k][1];
    m_st[k][1] = m_st[k][2];
    m_st[k][2] = m_st[k][3];
    m_st[k][3] = nw;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_st[k][i] = 32'd0;
      m_ph[k] = 0;
      m_left[k] = 0;
    end
  endtask

  task automatic model_tick(input int k);
    if (seed_we) begin
      m_st[k][seed_idx] = seed_wdata;
      if ((m_st[k][0] | m_st[k][1] | m_st[k][2] | m_st[k][3]) == 32'd0) m_ph[k] = 0;
      else if (m_warm[k] == 0) m_ph[k] = 2;
      else begin
        m_ph[k] = 1;
        m_left[k] = m_warm[k] + 1;
      end
    end else if (m_ph[k] == 1) begin
      if (m_left[k] > 1) model_advance(k);
      m_left[k]--;
      if (m_left[k] == 0) m_ph[k] = 2;
    end else if (m_ph[k] == 2 && mask_ready) begin
      model_advance(k);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_mask [2];
    logic        e_seed [2];
    for (int k = 0; k < 2; k++) begin
      e_mask[k] = (m_ph[k] == 2) ? m_st[k][3] : 32'd0;
      e_seed[k] = (m_st[k][0] | m_st[k][1] | m_st[k][2] | m_st[k][3]) != 32'd0;
    end
    check("valid0", {31'd0, valid0}, {31'd0, m_ph[0] == 2});
    check("mask0", mask0, e_mask[0]);
    check("seeded0", {31'd0, seeded0}, {31'd0, e_seed[0]});
    check("valid4", {31'd0, valid4}, {31'd0, m_ph[1] == 2});
    check("mask4", mask4, e_mask[1]);
    check("seeded4", {31'd0, seeded4}, {31'd0, e_seed[1]});
  endtask

  task automatic cycle(input logic we, input logic [1:0] idx, input logic [31:0] d, input logic rdy);
    seed_we = we;
    seed_idx = idx;
    seed_wdata = d;
    mask_ready = rdy;
    if (!rst_ni) model_reset();
    else for (int k = 0; k < 2; k++) model_tick(k);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp5;
    int          n;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 32'd0, 1'b1);
    check("rst_valid0", {31'd0, valid0}, 32'd0);
    check("rst_mask4", mask4, 32'd0);
    rst_ni = 1'b1;
    cycle(1'b0, 2'd0, 32'd0, 1'b1);

    // Fifth output of the xorshift sequence from seeds 1,2,3,4
    m_st[0][0] = 32'd1; m_st[0][1] = 32'd2; m_st[0][2] = 32'd3; m_st[0][3] = 32'd4;
    for (int i = 0; i < 4; i++) model_advance(0);
    exp5 = m_st[0][3];
    model_reset();

    cycle(1'b1, 2'd0, 32'd1, 1'b0);
    cycle(1'b1, 2'd1, 32'd2, 1'b0);
    cycle(1'b1, 2'd2, 32'd3, 1'b0);
    cycle(1'b1, 2'd3, 32'd4, 1'b0);
    check("w0_first_valid", {31'd0, valid0}, 32'd1);
    check("w0_first_mask", mask0, 32'h0000_0004);

    // Stall on the W=0 instance while the W=4 instance warms up
    n = 0;
    while (!valid4 && n < 20) begin
      cycle(1'b0, 2'd0, 32'd0, 1'b0);
      n++;
      if (n <= 5) check("w0_stall_mask", mask0, 32'h0000_0004);
    end
    check("w4_invalid_cycles", n, 32'd5);
    check("w4_first_mask", mask4, exp5);
    check("w0_seeded", {31'd0, seeded0}, 32'd1);

    cycle(1'b0, 2'd0, 32'd0, 1'b1);
    check("w0_hs1", mask0, 32'h0000_080D);
    cycle(1'b0, 2'd0, 32'd0, 1'b1);
    check("w0_hs2", mask0, 32'h0000_181F);

    // Seed write colliding with a handshake
    cycle(1'b1, 2'd3, 32'h0000_00FF, 1'b1);
    check("w0_seed_hs", mask0, 32'h0000_00FF);
    check("w4_restart", {31'd0, valid4}, 32'd0);
    cycle(1'b0, 2'd0, 32'd0, 1'b1);

    // Asynchronous reset mid-warmup
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid4", {31'd0, valid4}, 32'd0);
    check("arst_mask0", mask0, 32'd0);
    check("arst_seeded4", {31'd0, seeded4}, 32'd0);
    model_reset();
    cycle(1'b0, 2'd0, 32'd0, 1'b1);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 2'd0, 32'd0, 1'b1);

    // Zero seed leaves the block unseeded
    cycle(1'b1, 2'd0, 32'd0, 1'b1);
    check("zero_seed", {31'd0, seeded0}, 32'd0);
    cycle(1'b1, 2'd3, 32'd1, 1'b0);
    check("nz_seed_w4", {31'd0, valid4}, 32'd0);
    check("nz_seed_w0", mask0, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        cycle(1'b1, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom, 1'($urandom));
      else
        cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
